// File: rtl/dff_pkg.sv
// Shared constants and the transaction record used around the d_ff register.
package dff_pkg;

  localparam int unsigned DefaultWidth = 1;
  localparam logic [DefaultWidth-1:0] DefaultResetVal = '0;

  // One cycle of stimulus together with the response expected after the edge.
  typedef struct packed {
    logic [DefaultWidth-1:0] d;
    logic                    reset;
    logic [DefaultWidth-1:0] exp_q;
    logic [DefaultWidth-1:0] exp_qb;
  } dff_txn_t;

  // Next-state rule shared by every bit: reset wins over data.
  function automatic logic dff_next(input logic reset, input logic rst_val, input logic d);
    return reset ? rst_val : d;
  endfunction

endpackage

// File: rtl/d_ff_bit.sv
// Single-bit positive-edge flop with synchronous active-high reset and complement output.
module d_ff_bit
  import dff_pkg::*;
#(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o,
  output logic qb_o
);

  logic q_d, q_q;

  // Next state: reset value when reset is sampled high, otherwise the data bit.
  always_comb begin
    q_d = dff_next(reset_i, ResetVal, d_i);
  end

  // State register; reset is only seen on the rising edge.
  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  // qb is derived from the same register so q and qb can never agree.
  always_comb begin
    q_o  = q_q;
    qb_o = ~q_q;
  end

endmodule

// File: rtl/d_ff.sv
// WIDTH-bit D register with synchronous active-high reset and complementary output.
module d_ff
  import dff_pkg::*;
#(
  parameter int unsigned           WIDTH     = DefaultWidth,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qb_o
);

  // One independent flop per bit, each with its own reset value bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_ff_bit #(
      .ResetVal (RESET_VAL[i])
    ) u_bit (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d_i     (d_i[i]),
      .q_o     (q_o[i]),
      .qb_o    (qb_o[i])
    );
  end

`ifndef SYNTHESIS
  // Complement must hold whenever q is known.
  a_qb_compl: assert property (@(posedge clk_i) !$isunknown(q_o) |-> (qb_o == ~q_o));

  // One edge after reset is sampled high, q carries the reset value.
  a_reset_val: assert property (@(posedge clk_i) (reset_i === 1'b1) |=> (q_o == RESET_VAL));

  // Outside reset, q is the data sampled on the previous edge.
  a_capture: assert property (@(posedge clk_i) (reset_i === 1'b0) |=> (q_o == $past(d_i)));
`endif

endmodule

// File: tb/tb_d_ff.sv
// Directed and random checks of d_ff at WIDTH=1 (default reset) and WIDTH=8 (reset 8'hA5).
module tb_d_ff;

  localparam logic [7:0] Rv8 = 8'hA5;

  logic       clk;
  logic       rst1, rst8;
  logic [0:0] d1, q1, qb1;
  logic [7:0] d8, q8, qb8;

  int pass_cnt;
  int total_cnt;

  d_ff u_dut1 (
    .clk_i   (clk),
    .reset_i (rst1),
    .d_i     (d1),
    .q_o     (q1),
    .qb_o    (qb1)
  );

  d_ff #(
    .WIDTH     (8),
    .RESET_VAL (Rv8)
  ) u_dut8 (
    .clk_i   (clk),
    .reset_i (rst8),
    .d_i     (d8),
    .q_o     (q8),
    .qb_o    (qb8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs driven and outputs sampled here are off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic exp_q);
    total_cnt++;
    if (q1 !== exp_q || qb1 !== ~exp_q) begin
      $display("FAIL %s: q=%b qb=%b, required q=%b qb=%b", name, q1, qb1, exp_q, ~exp_q);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    d1   = 1'b1;
    tick();
    chk1("reset_edge1", 1'b0);
    tick();
    chk1("reset_edge2", 1'b0);
  endtask

  task automatic test_capture();
    logic [4:0] pat;
    pat  = 5'b01101;  // sequence 1,0,1,1,0 read from bit 0 upward
    rst1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d1 = pat[i];
      tick();
      chk1($sformatf("capture_%0d", i), pat[i]);
    end
  endtask

  task automatic test_glitch();
    d1 = 1'b0;
    tick();
    chk1("glitch_pre", 1'b0);
    #1 d1 = 1'b1;
    #2 d1 = 1'b0;
    #1 d1 = 1'b1;
    #1 d1 = 1'b0;
    chk1("glitch_mid", 1'b0);
    tick();
    chk1("glitch_post", 1'b0);
  endtask

  task automatic test_mid_reset();
    d1 = 1'b1;
    tick();
    chk1("midrst_q1", 1'b1);
    // Reset raised between edges must not touch q until the edge.
    #1 rst1 = 1'b1;
    #1 chk1("midrst_async", 1'b1);
    tick();
    chk1("midrst_forced", 1'b0);
    rst1 = 1'b0;
    tick();
    chk1("midrst_release", 1'b1);
  endtask

  task automatic test_coincide();
    rst1 = 1'b1;
    d1   = 1'b1;
    tick();
    chk1("coincide", 1'b0);
    rst1 = 1'b0;
    tick();
    chk1("coincide_release", 1'b1);
  endtask

  task automatic test_reset8();
    rst8 = 1'b1;
    d8   = 8'h3C;
    tick();
    total_cnt++;
    if (q8 !== 8'hA5 || qb8 !== 8'h5A) begin
      $display("FAIL reset8: q=%h qb=%h, required q=a5 qb=5a", q8, qb8);
    end else begin
      pass_cnt++;
    end
    rst8 = 1'b0;
    tick();
    total_cnt++;
    if (q8 !== 8'h3C || qb8 !== 8'hC3) begin
      $display("FAIL capture8: q=%h qb=%h, required q=3c qb=c3", q8, qb8);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic       exp1;
    logic [7:0] exp8;
    int         err1, err8;
    err1 = 0;
    err8 = 0;
    for (int n = 0; n < 1000; n++) begin
      d1   = 1'($urandom);
      d8   = 8'($urandom);
      rst1 = ($urandom_range(0, 99) < 5);
      rst8 = ($urandom_range(0, 99) < 5);
      exp1 = rst1 ? 1'b0 : d1;
      exp8 = rst8 ? Rv8 : d8;
      tick();
      total_cnt++;
      if (q1 !== exp1 || qb1 !== ~exp1) begin
        if (err1 < 5) $display("FAIL random1 cycle %0d: q=%b qb=%b, required q=%b", n, q1, qb1, exp1);
        err1++;
      end else begin
        pass_cnt++;
      end
      total_cnt++;
      if (q8 !== exp8 || qb8 !== ~exp8) begin
        if (err8 < 5) $display("FAIL random8 cycle %0d: q=%h qb=%h, required q=%h", n, q8, qb8, exp8);
        err8++;
      end else begin
        pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst1 = 1'b1;
    rst8 = 1'b1;
    d1   = 1'b0;
    d8   = 8'h00;
    #2;
    test_reset();
    test_capture();
    test_glitch();
    test_mid_reset();
    test_coincide();
    test_reset8();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
